// File: rtl/simon_seq_engine.sv
// Simon-style memory game: grows a random colour sequence, plays it on the lamps, checks the echo, scores.
// Define SIMON_TIMEOUT_EN to give up (LOST) after TIMEOUT_CYC idle cycles in INPUT.
// state | meaning
// IDLE  | waiting for Start        ADD   | append one random colour
// SHOW  | lamp on for one colour   GAP   | blank between colours
// INPUT | waiting for a press      CHECK | compare press with sequence
// LOST  | wrong press, hold score  WON   | full sequence echoed
// OFF   | power switch off
module simon_seq_engine #(
  parameter int NUM_BTN     = 4,
  parameter int MAX_LEVEL   = 16,
  parameter int SHOW_CYC    = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       On,
  input  logic [NUM_BTN-1:0]         Btn,
  input  logic [15:0]                Seed,
  output logic                       show_valid,
  output logic [$clog2(NUM_BTN)-1:0] show_idx,
  output logic [$clog2(NUM_BTN)-1:0] press_idx,
  output logic [5:0]                 level,
  output logic [15:0]                score,
  output logic [8:0]                 q_state
);

  localparam int CW = $clog2(NUM_BTN);
  localparam int AW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int TW = $clog2(((SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC) + 1);

  localparam logic [8:0] S_IDLE  = 9'h001;
  localparam logic [8:0] S_ADD   = 9'h002;
  localparam logic [8:0] S_SHOW  = 9'h004;
  localparam logic [8:0] S_GAP   = 9'h008;
  localparam logic [8:0] S_INPUT = 9'h010;
  localparam logic [8:0] S_CHECK = 9'h020;
  localparam logic [8:0] S_LOST  = 9'h040;
  localparam logic [8:0] S_WON   = 9'h080;
  localparam logic [8:0] S_OFF   = 9'h100;

  logic [8:0]    state;
  logic [CW-1:0] seq_mem [MAX_LEVEL];
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [5:0]    ptr;
  logic [5:0]    ptr_inc;
  logic [TW-1:0] tmr;
  logic          held;
  logic          btn_one;
  logic [CW-1:0] btn_idx;
  logic [CW-1:0] seq_rd;
  logic [CW-1:0] rnd_color;
  logic          press_ok;
  logic [16:0]   score_sum;
  logic          to_expire;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rnd_color = CW'(lfsr[7:0] % 8'(NUM_BTN));
  assign ptr_inc   = ptr + 6'd1;
  assign btn_one   = $onehot(Btn);
  assign score_sum = {1'b0, score} + {11'b0, level};

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (Btn[i]) btn_idx = CW'(i);
  end

  // The RAM is only looked at while ptr indexes a written entry.
  assign seq_rd   = (state == S_SHOW || state == S_CHECK) ? seq_mem[ptr[AW-1:0]] : '0;
  assign press_ok = (press_idx == seq_rd);

  always_ff @(posedge Clk) begin
    if (state == S_ADD) seq_mem[level[AW-1:0]] <= rnd_color;
  end

`ifdef SIMON_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  logic [TOW-1:0] to_cnt;
  logic           to_load;

  assign to_load = (state == S_GAP && tmr == '0 && ptr_inc == level) ||
                   (state == S_CHECK && press_ok && ptr_inc < level) ||
                   (state == S_INPUT && !held && btn_one);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      to_cnt <= '0;
    else if (to_load)
      to_cnt <= TOW'(TIMEOUT_CYC - 1);
    else if (state == S_INPUT && !held && to_cnt != '0)
      to_cnt <= to_cnt - TOW'(1);
  end

  assign to_expire = (state == S_INPUT) && !held && !btn_one && (to_cnt == '0);
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      level     <= '0;
      score     <= '0;
      press_idx <= '0;
      ptr       <= '0;
      tmr       <= '0;
      held      <= 1'b0;
      lfsr      <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (!On) begin
        state <= S_OFF;
        level <= '0;
        score <= '0;
        ptr   <= '0;
        tmr   <= '0;
        held  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            level <= '0;
            score <= '0;
            ptr   <= '0;
            held  <= 1'b0;
            if (Start) begin
              lfsr  <= (Seed == 16'h0000) ? 16'hACE1 : Seed;
              state <= S_ADD;
            end
          end
          S_ADD: begin
            level <= level + 6'd1;
            ptr   <= '0;
            tmr   <= TW'(SHOW_CYC - 1);
            state <= S_SHOW;
          end
          S_SHOW: begin
            if (tmr == '0) begin
              tmr   <= TW'(GAP_CYC - 1);
              state <= S_GAP;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          S_GAP: begin
            if (tmr != '0) begin
              tmr <= tmr - TW'(1);
            end else if (ptr_inc == level) begin
              ptr   <= '0;
              held  <= 1'b0;
              state <= S_INPUT;
            end else begin
              ptr   <= ptr_inc;
              tmr   <= TW'(SHOW_CYC - 1);
              state <= S_SHOW;
            end
          end
          S_INPUT: begin
            if (held) begin
              if (Btn == '0) begin
                held  <= 1'b0;
                state <= S_CHECK;
              end
            end else if (btn_one) begin
              press_idx <= btn_idx;
              held      <= 1'b1;
            end else if (to_expire) begin
              state <= S_LOST;
            end
          end
          S_CHECK: begin
            if (!press_ok) begin
              state <= S_LOST;
            end else if (ptr_inc < level) begin
              ptr   <= ptr_inc;
              state <= S_INPUT;
            end else begin
              score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
              state <= (level == 6'(MAX_LEVEL)) ? S_WON : S_ADD;
            end
          end
          S_LOST, S_WON: begin
            if (!Start) begin
              level <= '0;
              score <= '0;
              ptr   <= '0;
              state <= S_IDLE;
            end
          end
          S_OFF: begin
            if (!Start) state <= S_IDLE;
          end
          default: begin
            level <= '0;
            score <= '0;
            ptr   <= '0;
            held  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign show_valid = (state == S_SHOW);
  assign show_idx   = show_valid ? seq_rd : '0;
  assign q_state    = state;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine: game-level reference model compared every cycle, plus directed literal checks.
module tb_simon_seq_engine;

  localparam int NB = 4;
  localparam int ML = 4;
  localparam int SC = 4;
  localparam int GC = 2;
  localparam int TO = 10;
  localparam int CW = 2;

  localparam int P_IDLE = 0, P_ADD = 1, P_SHOW = 2, P_GAP = 3, P_INPUT = 4;
  localparam int P_CHECK = 5, P_LOST = 6, P_WON = 7, P_OFF = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          On = 1'b1;
  logic [NB-1:0] Btn = '0;
  logic [15:0]   Seed = '0;
  logic          show_valid;
  logic [CW-1:0] show_idx;
  logic [CW-1:0] press_idx;
  logic [5:0]    level;
  logic [15:0]   score;
  logic [8:0]    q_state;

  int errors = 0;
  int checks = 0;

  simon_seq_engine #(
    .NUM_BTN(NB), .MAX_LEVEL(ML), .SHOW_CYC(SC), .GAP_CYC(GC), .TIMEOUT_CYC(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .On(On), .Btn(Btn), .Seed(Seed),
    .show_valid(show_valid), .show_idx(show_idx), .press_idx(press_idx),
    .level(level), .score(score), .q_state(q_state)
  );

  initial forever #5 Clk = ~Clk;

  // Reference model: game phase, elapsed cycles in phase, colour queue (its length is the level).
  int            m_phase = P_IDLE;
  int            m_el = 0;
  int            m_ptr = 0;
  int            m_wait = 0;
  bit            m_held = 1'b0;
  logic [15:0]   m_lfsr = 16'hACE1;
  logic [15:0]   m_cur;
  int            m_score = 0;
  logic [CW-1:0] m_press = '0;
  int            m_seq[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic int btn_index(input logic [NB-1:0] b);
    int r = 0;
    for (int i = 0; i < NB; i++) if (b[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_el = 0; m_ptr = 0; m_wait = 0; m_held = 1'b0;
    m_lfsr = 16'hACE1; m_score = 0; m_press = '0; m_seq.delete();
  endtask

  task automatic enter_input();
    m_phase = P_INPUT; m_held = 1'b0; m_wait = 0;
  endtask

  task automatic model_step();
    m_cur  = m_lfsr;
    m_lfsr = lfsr_step(m_cur);
    if (!On) begin
      m_phase = P_OFF; m_seq.delete(); m_score = 0; m_ptr = 0; m_held = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_seq.delete(); m_score = 0; m_ptr = 0;
          if (Start) begin
            m_lfsr  = (Seed == 16'h0000) ? 16'hACE1 : Seed;
            m_phase = P_ADD;
          end
        end
        P_ADD: begin
          m_seq.push_back(int'(m_cur[7:0]) % NB);
          m_ptr = 0; m_el = 0; m_phase = P_SHOW;
        end
        P_SHOW: begin
          m_el++;
          if (m_el == SC) begin m_el = 0; m_phase = P_GAP; end
        end
        P_GAP: begin
          m_el++;
          if (m_el == GC) begin
            m_el = 0;
            if (m_ptr + 1 == m_seq.size()) begin m_ptr = 0; enter_input(); end
            else begin m_ptr++; m_phase = P_SHOW; end
          end
        end
        P_INPUT: begin
          if (m_held) begin
            if (Btn == '0) m_phase = P_CHECK;
          end else if ($countones(Btn) == 1) begin
            m_press = CW'(btn_index(Btn)); m_held = 1'b1;
          end else begin
            m_wait++;
`ifdef SIMON_TIMEOUT_EN
            if (m_wait == TO) m_phase = P_LOST;
`endif
          end
        end
        P_CHECK: begin
          if (int'(m_press) != m_seq[m_ptr]) m_phase = P_LOST;
          else if (m_ptr + 1 < m_seq.size()) begin m_ptr++; enter_input(); end
          else begin
            m_score = (m_score + m_seq.size() > 65535) ? 65535 : m_score + m_seq.size();
            m_phase = (m_seq.size() == ML) ? P_WON : P_ADD;
          end
        end
        P_LOST, P_WON: begin
          if (!Start) begin m_phase = P_IDLE; m_seq.delete(); m_score = 0; m_ptr = 0; end
        end
        P_OFF: if (!Start) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge Clk or posedge Reset);
    if (Reset) model_reset();
    else model_step();
  end

  function automatic logic [35:0] model_vec();
    logic          sv;
    logic [CW-1:0] si;
    sv = (m_phase == P_SHOW);
    si = sv ? CW'(m_seq[m_ptr]) : '0;
    return {9'(1 << m_phase), 6'(m_seq.size()), m_score[15:0], sv, si, m_press};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: got no event within bound expected event", name, $time);
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge Clk);
    check("cycle", {q_state, level, score, show_valid, show_valid ? show_idx : CW'(0), press_idx},
          model_vec());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_phase(input int ph, input string name);
    int n = 0;
    while (m_phase != ph && n < 500) begin @(negedge Clk); n++; end
    if (n >= 500) bound_fail(name);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(m_phase == P_INPUT && !m_held) && n < 500) begin @(negedge Clk); n++; end
    if (n >= 500) bound_fail("wait_ready");
  endtask

  task automatic press(input int idx);
    Btn = NB'(1) << idx;
    tick(1);
    Btn = '0;
    tick(1);
  endtask

  task automatic echo_level();
    int n;
    wait_ready();
    n = m_seq.size();
    for (int i = 0; i < n; i++) begin
      wait_ready();
      press(m_seq[i]);
    end
  endtask

  task automatic start_game(input logic [15:0] s);
    wait_phase(P_IDLE, "wait_idle");
    Seed  = s;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  int rises, highs, lows, run, n;
  bit prev;

  initial begin
    #1 Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    check("reset_state", q_state, 9'h001);
    check("reset_level", level, 6'd0);
    check("reset_score", score, 16'd0);
    check("reset_show", show_valid, 1'b0);

    // Start latency and first colour (0x34 mod 4 = 0), then echo to level 4.
    Seed  = 16'h1234;
    Start = 1'b1;
    tick(1);
    check("lat_add_state", q_state, 9'h002);
    check("lat_show_low", show_valid, 1'b0);
    Start = 1'b0;
    tick(1);
    check("lat_show_high", show_valid, 1'b1);
    check("first_color_1234", show_idx, 2'd0);
    for (int lv = 1; lv <= 3; lv++) echo_level();
    wait_phase(P_SHOW, "wait_show_l4");
    check("l4_level", level, 6'd4);
    check("l4_score", score, 16'd6);
    rises = 0; highs = 0; lows = 0; run = 0; prev = 1'b0; n = 0;
    while (q_state !== 9'h010 && n < 200) begin
      if (show_valid && !prev) rises++;
      if (show_valid) begin highs++; run++; end
      else begin
        lows++;
        if (prev) check("pulse_width", run, SC);
        run = 0;
      end
      prev = show_valid;
      tick(1);
      n++;
    end
    if (n >= 200) bound_fail("l4_show_span");
    check("l4_pulses", rises, 4);
    check("l4_high_cycles", highs, 16);
    check("l4_gap_cycles", lows, 8);
    echo_level();
    wait_phase(P_WON, "wait_won");
    Start = 1'b1;
    tick(4);
    check("won_hold_state", q_state, 9'h080);
    check("won_score", score, 16'd10);
    check("won_level", level, 6'd4);
    On = 1'b0;
    tick(1);
    check("off_state", q_state, 9'h100);
    check("off_score", score, 16'd0);
    check("off_level", level, 6'd0);
    On = 1'b1;
    Start = 1'b0;
    tick(1);
    check("off_to_idle", q_state, 9'h001);

    // Wrong press at position 0 of level 2, Start held so LOST holds.
    start_game(16'h00FF);
    echo_level();
    wait_ready();
    Start = 1'b1;
    press((m_seq[0] + 1) % NB);
    check("wrong_check_state", q_state, 9'h020);
    tick(1);
    check("lost_state", q_state, 9'h040);
    check("lost_level", level, 6'd2);
    check("lost_score", score, 16'd1);
    tick(3);
    check("lost_hold", q_state, 9'h040);
    Start = 1'b0;
    tick(1);
    check("lost_to_idle", q_state, 9'h001);

    // Seed 0 selects 16'hACE1 (0xE1 mod 4 = 1); buttons during SHOW and multi-bit presses are ignored.
    start_game(16'h0000);
    tick(1);
    check("first_color_ace1", show_idx, 2'd1);
    Btn = 4'b0010;
    tick(3);
    Btn = '0;
    wait_ready();
    Btn = 4'b0011;
    tick(2);
    check("multi_ignored", q_state, 9'h010);
    Btn = 4'b0100;
    tick(1);
    Btn = 4'b0000;
    tick(1);
    check("press_check_state", q_state, 9'h020);
    check("press_idx_2", press_idx, 2'd2);
    tick(1);
    check("press2_lost", q_state, 9'h040);
    tick(1);

    // Asynchronous reset during SHOW of level 3.
    start_game(16'h1234);
    echo_level();
    echo_level();
    wait_phase(P_SHOW, "wait_show_l3");
    check("l3_level", level, 6'd3);
    tick(2);
    #1 Reset = 1'b1;
    #1;
    check("async_rst_state", q_state, 9'h001);
    check("async_rst_show", show_valid, 1'b0);
    tick(1);
    check("rst_state", q_state, 9'h001);
    check("rst_level", level, 6'd0);
    check("rst_score", score, 16'd0);
    check("rst_show", show_valid, 1'b0);
    Reset = 1'b0;
    tick(1);

    // No press at all in INPUT.
    start_game(16'hBEEF);
    wait_ready();
`ifdef SIMON_TIMEOUT_EN
    n = 0;
    while (q_state !== 9'h040 && n < 50) begin tick(1); n++; end
    check("timeout_cycles", n, TO);
`else
    tick(10000);
    check("no_timeout_state", q_state, 9'h010);
`endif
    On = 1'b0;
    tick(2);
    check("final_off", q_state, 9'h100);
    On = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
